// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 at the end of the M stage.
// Holds SR, Cause, EPC and PRId, decides whether the pipeline traps,
// and serves mtc0 / mfc0 / eret.
// Optional build macro CP0_TIMER_EN adds Count (reg 9), Compare (reg 11)
// and the timer interrupt flag Cause.TI (bit 30), gated by SR bit 15.
module cp0_unit #(
  parameter logic [31:0] PRID    = 32'h0000_2019,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic [5:0]  exccode_m,
  input  logic        bd_m,
  input  logic [5:0]  hwint,
  input  logic        we,
  input  logic        eret_m,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [31:0] epc,
  output logic        req,
  output logic [31:0] handler_pc
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;
  logic        cause_ti;
  logic        int_req;
  logic        exc_req;
  logic        wr_en;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign sr_val    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
  assign cause_val = {cause_bd, cause_ti, 14'b0, cause_ip, 3'b0, cause_exc, 2'b0};

  // Trap decision from current register state; EXL masks everything.
  assign int_req = ((|(hwint & sr_im)) | (cause_ti & sr_im[5])) & sr_ie & ~sr_exl;
  assign exc_req = (|exccode_m) & ~sr_exl;
  assign req     = int_req | exc_req;

  // A trap in the same cycle swallows any mtc0 or eret.
  assign wr_en      = we & ~req;
  assign epc        = epc_q;
  assign handler_pc = HANDLER;

`ifdef CP0_TIMER_EN
  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;

  logic [31:0] count_q;
  logic [31:0] compare_q;

  // Free-running Count; an mtc0 replaces the increment for that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 32'h0;
    end else if (wr_en && cp0_addr == ADDR_COUNT) begin
      count_q <= din;
    end else begin
      count_q <= count_q + 32'd1;
    end
  end

  // Compare register and the TI flag; writing Compare acknowledges TI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      compare_q <= 32'h0;
      cause_ti  <= 1'b0;
    end else if (wr_en && cp0_addr == ADDR_COMPARE) begin
      compare_q <= din;
      cause_ti  <= 1'b0;
    end else if (count_q == compare_q) begin
      cause_ti  <= 1'b1;
    end
  end
`else
  assign cause_ti = 1'b0;
`endif

  // SR: trap sets EXL, otherwise eret clears EXL and mtc0 loads IM/EXL/IE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im  <= 6'b0;
      sr_exl <= 1'b0;
      sr_ie  <= 1'b0;
    end else if (req) begin
      sr_exl <= 1'b1;
    end else begin
      if (eret_m) begin
        sr_exl <= 1'b0;
      end
      if (we && cp0_addr == ADDR_SR) begin
        sr_im  <= din[15:10];
        sr_exl <= din[1];
        sr_ie  <= din[0];
      end
    end
  end

  // Cause: IP tracks the interrupt lines every cycle; BD/ExcCode latch on a trap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cause_ip  <= 6'b0;
      cause_bd  <= 1'b0;
      cause_exc <= 5'b0;
    end else begin
      cause_ip <= hwint;
      if (req) begin
        cause_bd  <= bd_m;
        cause_exc <= int_req ? 5'd0 : exccode_m[4:0];
      end
    end
  end

  // EPC: restart address on a trap (branch address for a delay-slot victim).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc_q <= 32'h0;
    end else if (req) begin
      epc_q <= bd_m ? (pc_m - 32'd4) : pc_m;
    end else if (wr_en && cp0_addr == ADDR_EPC) begin
      epc_q <= din;
    end
  end

  // mfc0 read mux over current state.
  always_comb begin
    dout = 32'h0;
    case (cp0_addr)
      ADDR_SR:      dout = sr_val;
      ADDR_CAUSE:   dout = cause_val;
      ADDR_EPC:     dout = epc_q;
      ADDR_PRID:    dout = PRID;
`ifdef CP0_TIMER_EN
      ADDR_COUNT:   dout = count_q;
      ADDR_COMPARE: dout = compare_q;
`endif
      default:      dout = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Testbench for cp0_unit: directed scenarios plus randomized traffic
// compared against an architectural model of SR/Cause/EPC.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_m;
  logic [5:0]  exccode_m;
  logic        bd_m;
  logic [5:0]  hwint;
  logic        we;
  logic        eret_m;
  logic [4:0]  cp0_addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] epc;
  logic        req;
  logic [31:0] handler_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  cp0_unit dut (
    .clk(clk), .reset(reset), .pc_m(pc_m), .exccode_m(exccode_m),
    .bd_m(bd_m), .hwint(hwint), .we(we), .eret_m(eret_m),
    .cp0_addr(cp0_addr), .din(din), .dout(dout), .epc(epc),
    .req(req), .handler_pc(handler_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_2019;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_sr = 0; m_cause = 0; m_epc = 0;
  endtask

  // Drive one cycle of inputs at negedge, check outputs, then advance the model
  // to the state it holds after the following posedge.
  task automatic step(input logic [31:0] p, input logic [5:0] e, input logic b,
                      input logic [5:0] h, input logic w, input logic er,
                      input logic [4:0] a, input logic [31:0] d);
    logic irq, xrq, trap;
    @(negedge clk);
    pc_m = p; exccode_m = e; bd_m = b; hwint = h; we = w; eret_m = er;
    cp0_addr = a; din = d;
    #1;
    irq  = ((h & m_sr[15:10]) != 0) && m_sr[0] && !m_sr[1];
    xrq  = (e != 0) && !m_sr[1];
    trap = irq || xrq;
    chk("req", {31'b0, req}, {31'b0, trap});
    chk("dout", dout, model_read(a));
    chk("epc", epc, m_epc);
    m_cause = (m_cause & ~32'h0000_fc00) | (32'(h) << 10);
    if (trap) begin
      m_sr    = m_sr | 32'h2;
      m_cause = (m_cause & ~32'h8000_007c) | (32'(b) << 31) | (irq ? 32'h0 : (32'(e[4:0]) << 2));
      m_epc   = b ? p - 32'd4 : p;
    end else begin
      if (er) m_sr = m_sr & ~32'h2;
      if (w && a == 5'd12) m_sr = d & 32'h0000_fc03;
      if (w && a == 5'd14) m_epc = d;
    end
  endtask

  task automatic idle(input logic [4:0] a);
    step(32'h0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, a, 32'h0);
  endtask

  // Park Compare far away so the timer stays quiet during the non-timer tests.
  task automatic post_reset();
`ifdef CP0_TIMER_EN
    @(negedge clk);
    pc_m = 0; exccode_m = 0; bd_m = 0; hwint = 0; eret_m = 0;
    we = 1; cp0_addr = 5'd11; din = 32'hffff_fff0;
    @(negedge clk);
    we = 0;
`endif
  endtask

  initial begin
    logic [5:0] exc_tab [7] = '{6'd0, 6'd0, 6'd0, 6'd4, 6'd5, 6'd10, 6'd12};
    bit got_req;
    reset = 1; pc_m = 0; exccode_m = 0; bd_m = 0; hwint = 0; we = 0;
    eret_m = 0; cp0_addr = 0; din = 0;
    model_reset();
    #12;
    @(negedge clk);
    reset = 0;
    post_reset();

    chk("handler_pc", handler_pc, 32'h0000_4180);
    idle(5'd12);
    idle(5'd15);

    // Mid-cycle reset with live SR contents.
    step(32'h0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b0, 5'd12, 32'h0000_fc01);
    step(32'h0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 5'd12, 32'h0);
    chk("sr_pre_reset", dout, 32'h0000_fc01);
    #2 reset = 1;
    #1;
    chk("sr_reset", dout, 32'h0);
    chk("req_reset", {31'b0, req}, 32'h0);
    cp0_addr = 5'd13; #1 chk("cause_reset", dout, 32'h0);
    cp0_addr = 5'd14; #1 chk("epc_reset", dout, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 0;
    post_reset();

    // AdES outside a delay slot.
    step(32'h3008, 6'd5, 1'b0, 6'd0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(32'h3008, 6'd5, 1'b0, 6'd0, 1'b0, 1'b0, 5'd13, 32'h0);
    chk("ades_cause", dout, 32'h0000_0014);
    chk("ades_masked", {31'b0, req}, 32'h0);
    step(32'h0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 5'd14, 32'h0);
    chk("ades_epc", dout, 32'h0000_3008);
    step(32'h0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 5'd12, 32'h0);
    chk("ades_exl", dout, 32'h0000_0002);

    // AdEL in a delay slot.
    step(32'h3010, 6'd4, 1'b1, 6'd0, 1'b0, 1'b0, 5'd0, 32'h0);
    idle(5'd13);
    chk("adel_cause", dout, 32'h8000_0010);
    step(32'h0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 5'd14, 32'h0);
    chk("adel_epc", dout, 32'h0000_300c);

    // Interrupt beats Ov; concurrent mtc0 to SR is dropped.
    step(32'h0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b0, 5'd12, 32'h0000_0401);
    step(32'h4000, 6'd12, 1'b0, 6'd1, 1'b1, 1'b0, 5'd12, 32'h0);
    chk("int_req", {31'b0, req}, 32'h1);
    step(32'h0, 6'd0, 1'b0, 6'd1, 1'b0, 1'b0, 5'd13, 32'h0);
    chk("int_cause", dout, 32'h0000_0400);
    step(32'h0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 5'd12, 32'h0);
    chk("sr_write_dropped", dout, 32'h0000_0403);
    idle(5'd12);
    chk("eret_exl", dout, 32'h0000_0401);
    idle(5'd15);
    chk("prid", dout, 32'h0000_2019);

    // Delay-slot EPC wraps below zero.
    step(32'h0000_0002, 6'd10, 1'b1, 6'd0, 1'b0, 1'b0, 5'd0, 32'h0);
    step(32'h0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 5'd14, 32'h0);
    chk("epc_wrap", dout, 32'hffff_fffe);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      logic [5:0]  e, h;
      logic        er, w;
      logic [4:0]  a;
      e  = exc_tab[$urandom_range(0, 6)];
      h  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      er = ($urandom_range(0, 3) == 0);
      w  = !er && ($urandom_range(0, 2) == 0);
      a  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) a = 5'd12 + 5'($urandom_range(0, 3));
`ifdef CP0_TIMER_EN
      if (a == 5'd9 || a == 5'd11) a = 5'd10;
`endif
      step($urandom, e, 1'($urandom), h, w, er, a, $urandom);
    end

`ifdef CP0_TIMER_EN
    // Timer interrupt at Count == Compare, acknowledged by writing Compare.
    @(negedge clk);
    reset = 1;
    pc_m = 0; exccode_m = 0; bd_m = 0; hwint = 0; eret_m = 0; we = 0;
    @(negedge clk);
    reset = 0;
    we = 1; cp0_addr = 5'd11; din = 32'd5;
    @(negedge clk);
    we = 1; cp0_addr = 5'd12; din = 32'h0000_8001;
    @(negedge clk);
    we = 0; cp0_addr = 5'd9;
    got_req = 0;
    for (int k = 0; k < 20 && !got_req; k++) begin
      #1;
      if (req) got_req = 1;
      else @(negedge clk);
    end
    chk("ti_req", {31'b0, got_req}, 32'h1);
    chk("ti_count", dout, 32'd6);
    cp0_addr = 5'd13; #1;
    chk("ti_set", dout & 32'h4000_0000, 32'h4000_0000);
    @(negedge clk);
    we = 1; cp0_addr = 5'd11; din = 32'd1000;
    @(negedge clk);
    we = 0; cp0_addr = 5'd13; #1;
    chk("ti_clear", dout & 32'h4000_0000, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
